// File: rtl/l2_responder.sv
// l2_responder: L2-side responder for the L1->L2 request interface.
// It handles one request at a time from a word-addressed backing store.
// Read and write latencies are programmable. An error response always
// completes one cycle after the request is accepted.
module l2_responder #(
  parameter int unsigned            DATA_WIDTH    = 64,
  parameter int unsigned            ADDR_WIDTH    = 64,
  parameter int unsigned            ID_WIDTH      = 4,
  parameter int unsigned            MEM_WORDS     = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR     = '0,
  parameter int unsigned            READ_LATENCY  = 4,
  parameter int unsigned            WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] l1_addr,
  input  logic [DATA_WIDTH-1:0] l1_write_data,
  input  logic                  l1_read,
  input  logic                  l1_write,
  input  logic [ID_WIDTH-1:0]   l1_id,
  input  logic                  l1_request,
  output logic [DATA_WIDTH-1:0] l1_read_data,
  output logic                  l1_ready,
  output logic                  l1_error,
  output logic [ID_WIDTH-1:0]   resp_id,
  output logic [31:0]           reads_served,
  output logic [31:0]           writes_served,
  output logic [31:0]           error_count
);

  // Byte-offset bits inside one word, and the width of the word index.
  localparam int unsigned OFF_W   = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);
  localparam logic [CNT_W-1:0]      RD_LOAD    = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]      WR_LOAD    = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  ready_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   resp_id_q;
  logic [31:0]           reads_q;
  logic [31:0]           writes_q;
  logic [31:0]           errs_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Decode of the incoming request. It is only used on the acceptance edge.
  logic                  borrow_d;
  logic [ADDR_WIDTH-1:0] off_d;
  logic [ADDR_WIDTH-1:0] word_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  req_err_d;
  logic                  fast_d;
  logic [CNT_W-1:0]      load_d;

  // Request decode: word index, error classification and latency selection.
  always_comb begin
    // The borrow out of the subtraction flags addresses below the base.
    {borrow_d, off_d} = {1'b0, l1_addr} - {1'b0, BASE_ADDR};
    word_d    = off_d >> OFF_W;
    idx_d     = word_d[IDX_W-1:0];
    req_err_d = borrow_d
             || (word_d >= ADDR_WIDTH'(MEM_WORDS))
             || ((l1_addr & ALIGN_MASK) != '0)
             || (l1_read == l1_write);
    fast_d    = l1_read ? (READ_LATENCY == 1) : (WRITE_LATENCY == 1);
    load_d    = l1_read ? RD_LOAD : WR_LOAD;
  end

  // Control FSM. It also holds the latched request, the registered response and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      id_q      <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      resp_id_q <= '0;
      reads_q   <= '0;
      writes_q  <= '0;
      errs_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          if (l1_request) begin
            idx_q   <= idx_d;
            wdata_q <= l1_write_data;
            rd_q    <= l1_read;
            id_q    <= l1_id;
            cnt_q   <= load_d;
            if (req_err_d) begin
              // Bad request: answer with an error on the next cycle.
              state_q   <= S_RESP;
              ready_q   <= 1'b1;
              error_q   <= 1'b1;
              resp_id_q <= l1_id;
              errs_q    <= errs_q + 32'd1;
            end else if (fast_d) begin
              // A single-cycle latency skips WAIT and completes right away.
              state_q   <= S_RESP;
              ready_q   <= 1'b1;
              resp_id_q <= l1_id;
              if (l1_read) begin
                rdata_q <= mem_q[idx_d];
                reads_q <= reads_q + 32'd1;
              end else begin
                writes_q <= writes_q + 32'd1;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q   <= S_RESP;
            ready_q   <= 1'b1;
            resp_id_q <= id_q;
            if (rd_q) begin
              rdata_q <= mem_q[idx_q];
              reads_q <= reads_q + 32'd1;
            end else begin
              writes_q <= writes_q + 32'd1;
            end
          end
        end

        S_RESP: begin
          // The ready pulse lasts exactly one cycle. Read data stays registered.
          ready_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Backing store. A successful write commits on the edge that leaves RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if ((state_q == S_RESP) && !error_q && !rd_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign l1_read_data  = rdata_q;
  assign l1_ready      = ready_q;
  assign l1_error      = error_q;
  assign resp_id       = resp_id_q;
  assign reads_served  = reads_q;
  assign writes_served = writes_q;
  assign error_count   = errs_q;

endmodule

// File: tb/tb_l2_responder.sv
// Testbench for l2_responder with default parameters.
// It runs directed scenarios and then randomized traffic, all checked
// against a word-array reference model.
module tb_l2_responder;

  localparam int RL    = 4;
  localparam int WL    = 2;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] l1_addr;
  logic [63:0] l1_write_data;
  logic        l1_read;
  logic        l1_write;
  logic [3:0]  l1_id;
  logic        l1_request;
  logic [63:0] l1_read_data;
  logic        l1_ready;
  logic        l1_error;
  logic [3:0]  resp_id;
  logic [31:0] reads_served;
  logic [31:0] writes_served;
  logic [31:0] error_count;

  l2_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .l1_addr       (l1_addr),
    .l1_write_data (l1_write_data),
    .l1_read       (l1_read),
    .l1_write      (l1_write),
    .l1_id         (l1_id),
    .l1_request    (l1_request),
    .l1_read_data  (l1_read_data),
    .l1_ready      (l1_ready),
    .l1_error      (l1_error),
    .resp_id       (resp_id),
    .reads_served  (reads_served),
    .writes_served (writes_served),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mdl_mem [WORDS];
  logic [63:0] mdl_rdata;
  logic [3:0]  mdl_id;
  int unsigned mdl_reads, mdl_writes, mdl_errs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = '0;
    mdl_rdata  = '0;
    mdl_id     = '0;
    mdl_reads  = 0;
    mdl_writes = 0;
    mdl_errs   = 0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".reads"},  64'(reads_served),  64'(mdl_reads));
    check({tag, ".writes"}, 64'(writes_served), 64'(mdl_writes));
    check({tag, ".errors"}, 64'(error_count),   64'(mdl_errs));
  endtask

  // One transaction. Call it while the DUT is IDLE; it returns in the next IDLE cycle.
  // hold=1 keeps l1_request high through WAIT/RESP while driving garbage
  // on the other inputs.
  task automatic txn(input string tag, input logic [63:0] addr, input logic rd, input logic wr,
                     input logic [63:0] data, input logic [3:0] id, input bit hold);
    logic [63:0] idx;
    bit          err;
    int          lat;
    int          cyc;
    bit          seen;
    idx = addr >> 3;
    err = (addr[2:0] != 3'd0) || (idx >= 64'(WORDS)) || (rd == wr);
    lat = err ? 1 : (rd ? RL : WL);

    l1_addr       = addr;
    l1_write_data = data;
    l1_read       = rd;
    l1_write      = wr;
    l1_id         = id;
    l1_request    = 1'b1;
    @(posedge clk);
    #1;
    l1_addr       = {$urandom, $urandom};
    l1_write_data = {$urandom, $urandom};
    l1_read       = 1'($urandom);
    l1_write      = 1'($urandom);
    l1_id         = 4'($urandom);
    l1_request    = hold;

    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (l1_ready === 1'b1) seen = 1'b1;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));

    if (seen) begin
      if (err) begin
        mdl_errs++;
      end else if (rd) begin
        mdl_rdata = mdl_mem[idx[9:0]];
        mdl_reads++;
      end else begin
        mdl_mem[idx[9:0]] = data;
        mdl_writes++;
      end
      mdl_id = id;
      check({tag, ".error"},   64'(l1_error), 64'(err));
      check({tag, ".rdata"},   l1_read_data,  mdl_rdata);
      check({tag, ".resp_id"}, 64'(resp_id),  64'(mdl_id));
    end

    @(posedge clk);
    #1;
    l1_request = 1'b0;
    check({tag, ".ready_drop"}, 64'(l1_ready), 64'd0);
    check({tag, ".rdata_hold"}, l1_read_data, mdl_rdata);
    check_counters(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic        rd, wr;
    int          kind;

    rst_n         = 1'b0;
    l1_addr       = '0;
    l1_write_data = '0;
    l1_read       = 1'b0;
    l1_write      = 1'b0;
    l1_id         = '0;
    l1_request    = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset.ready",   64'(l1_ready), 64'd0);
    check("reset.error",   64'(l1_error), 64'd0);
    check("reset.rdata",   l1_read_data,  64'd0);
    check("reset.resp_id", 64'(resp_id),  64'd0);
    check_counters("reset");
    rst_n = 1'b1;

    // Plain read from a freshly reset store
    txn("rd0", 64'h0, 1'b1, 1'b0, 64'h0, 4'd1, 1'b0);

    // Write followed by a back-to-back read with request held
    txn("wr40", 64'h40, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D, 4'd3, 1'b1);
    txn("rd40", 64'h40, 1'b1, 1'b0, 64'h0, 4'd3, 1'b1);

    // Out-of-range and unaligned errors. Read data must be kept.
    txn("err_range", 64'h2000, 1'b1, 1'b0, 64'h0, 4'd5, 1'b0);
    txn("err_align", 64'h44,   1'b1, 1'b0, 64'h0, 4'd6, 1'b0);

    // Both command bits set at 0x8, then check the word was untouched
    txn("err_both", 64'h8, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 4'd7, 1'b0);
    txn("rd8",      64'h8, 1'b1, 1'b0, 64'h0, 4'd7, 1'b0);
    txn("err_none", 64'h8, 1'b0, 1'b0, 64'h0, 4'd8, 1'b0);

    // Last word of the store is in range
    txn("wr_last", 64'h1FF8, 1'b0, 1'b1, 64'hA5A5_0000_FFFF_1111, 4'd9, 1'b1);
    txn("rd_last", 64'h1FF8, 1'b1, 1'b0, 64'h0, 4'd10, 1'b0);

    // Reset during WAIT of a write discards it
    l1_addr       = 64'h10;
    l1_write_data = 64'h55;
    l1_read       = 1'b0;
    l1_write      = 1'b1;
    l1_id         = 4'd2;
    l1_request    = 1'b1;
    @(posedge clk);
    #1;
    l1_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstwait.ready", 64'(l1_ready), 64'd0);
    @(negedge clk);
    check("rstwait.ready2", 64'(l1_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rstwait.ready3", 64'(l1_ready), 64'd0);
    check("rstwait.rdata",  l1_read_data,  64'd0);
    check_counters("rstwait");
    txn("rd10", 64'h10, 1'b1, 1'b0, 64'h0, 4'd4, 1'b0);

    // Request dropped during WAIT of a read (hold=0)
    txn("wr18", 64'h18, 1'b0, 1'b1, 64'h0BAD_F00D_1357_2468, 4'd11, 1'b0);
    txn("rd18", 64'h18, 1'b1, 1'b0, 64'h0, 4'd12, 1'b0);

    // Randomized traffic over a small address window, with error cases mixed in
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      a    = 64'($urandom_range(0, 15)) << 3;
      rd   = 1'($urandom);
      wr   = ~rd;
      if (kind == 0) a = a | 64'($urandom_range(1, 7));
      if (kind == 1) a = 64'h2000 + (64'($urandom_range(0, 255)) << 3);
      if (kind == 2) wr = rd;
      txn("rand", a, rd, wr, {$urandom, $urandom}, 4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
